idma_obi_burst_read: RTL

OBI read manager for the iDMA transport layer that fetches a multi-beat burst from a descriptor and keeps up to `MaxOutstanding` OBI reads in flight. Its predecessor handled one beat per request. Read data goes through an internal response FIFO that is credit-reserved, so `rvalid` (OBI has no response back-pressure) is never dropped. The block sits between the read-meta/datapath side of the backend and the OBI read port. It feeds the read barrel shifter and dataflow buffer, and reports one completion per descriptor.

---
 rtl/idma_obi_burst_read.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/idma_obi_burst_read.sv
`default_nettype none
//----------------------------------------------------------------------------
// idma_obi_burst_read: multi-beat OBI read manager with credit-reserved
// response FIFO and per-descriptor completion.  Revision 1.0
//----------------------------------------------------------------------------
module idma_obi_burst_read #(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned LenWidth       = 16,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [AddrWidth-1:0]              desc_addr_i,
  input  logic [LenWidth-1:0]               desc_len_i,
  input  logic                              desc_valid_i,
  output logic                              desc_ready_o,
  output logic                              obi_req_o,
  input  logic                              obi_gnt_i,
  output logic [AddrWidth-1:0]              obi_addr_o,
  output logic                              obi_we_o,
  output logic [DataWidth/8-1:0]            obi_be_o,
  input  logic                              obi_rvalid_i,
  input  logic [DataWidth-1:0]              obi_rdata_i,
  input  logic                              obi_err_i,
  output logic [DataWidth-1:0]              data_o,
  output logic                              data_err_o,
  output logic                              data_last_o,
  output logic                              data_valid_o,
  input  logic                              data_ready_i,
  output logic                              done_valid_o,
  input  logic                              done_ready_i,
  output logic                              done_err_o,
  output logic                              busy_o,
  output logic [$clog2(MaxOutstanding+1)-1:0] inflight_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned CntWidth  = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrWidth  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  localparam logic [AddrWidth-1:0] AlignMask   = ~AddrWidth'(StrbWidth - 1);
  localparam logic [AddrWidth-1:0] AddrStep    = AddrWidth'(StrbWidth);
  localparam logic [LenWidth:0]    OneBeat     = (LenWidth+1)'(1);
  localparam logic [CntWidth:0]    CreditLimit = (CntWidth+1)'(MaxOutstanding);
  localparam logic [PtrWidth-1:0]  LastSlot    = PtrWidth'(MaxOutstanding - 1);
  localparam logic [CntWidth-1:0]  CntOne      = CntWidth'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e               state;
  logic [AddrWidth-1:0] addr_q;
  logic [LenWidth:0]    issue_cnt;
  logic [LenWidth:0]    pop_cnt;
  logic                 req_q;
  logic                 ready_q;
  logic                 done_q;
  logic                 err_acc;
  logic                 stale_ok;

  logic [CntWidth-1:0]  inflight;
  logic [CntWidth-1:0]  fifo_cnt;
  logic [PtrWidth-1:0]  wr_ptr;
  logic [PtrWidth-1:0]  rd_ptr;
  logic [DataWidth:0]   fifo_mem [MaxOutstanding];

  logic                 gnt;
  logic                 rsp_accept;
  logic                 pop;
  logic                 desc_hs;
  logic [CntWidth-1:0]  inflight_nxt;
  logic [CntWidth-1:0]  fifo_cnt_nxt;
  logic                 credit_nxt;
  logic [LenWidth:0]    issue_cnt_nxt;

  assign gnt           = req_q & obi_gnt_i;
  // Responses with nothing outstanding (e.g. stragglers from before a reset) are dropped.
  assign rsp_accept    = obi_rvalid_i & (inflight != '0);
  assign pop           = data_valid_o & data_ready_i;
  assign desc_hs       = ready_q & desc_valid_i;
  assign issue_cnt_nxt = issue_cnt - {{LenWidth{1'b0}}, gnt};

  always_comb begin
    inflight_nxt = inflight;
    if (gnt && !rsp_accept) begin
      inflight_nxt = inflight + CntOne;
    end else if (!gnt && rsp_accept) begin
      inflight_nxt = inflight - CntOne;
    end
    fifo_cnt_nxt = fifo_cnt;
    if (rsp_accept && !pop) begin
      fifo_cnt_nxt = fifo_cnt + CntOne;
    end else if (!rsp_accept && pop) begin
      fifo_cnt_nxt = fifo_cnt - CntOne;
    end
  end

  // Credit looks at next-cycle occupancy so back-to-back grants keep req high.
  assign credit_nxt = ({1'b0, inflight_nxt} + {1'b0, fifo_cnt_nxt}) < CreditLimit;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      inflight <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= inflight_nxt;
      fifo_cnt <= fifo_cnt_nxt;
      if (rsp_accept) begin
        wr_ptr <= (wr_ptr == LastSlot) ? '0 : wr_ptr + PtrWidth'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LastSlot) ? '0 : rd_ptr + PtrWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rsp_accept) begin
      fifo_mem[wr_ptr] <= {obi_err_i, obi_rdata_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      addr_q    <= '0;
      issue_cnt <= '0;
      pop_cnt   <= '0;
      req_q     <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      err_acc   <= 1'b0;
      stale_ok  <= 1'b1;
    end else begin
      if (pop) begin
        pop_cnt <= pop_cnt - OneBeat;
        err_acc <= err_acc | data_err_o;
      end
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (desc_hs) begin
            ready_q   <= 1'b0;
            stale_ok  <= 1'b0;
            addr_q    <= desc_addr_i & AlignMask;
            issue_cnt <= {1'b0, desc_len_i} + OneBeat;
            pop_cnt   <= {1'b0, desc_len_i} + OneBeat;
            err_acc   <= 1'b0;
            req_q     <= credit_nxt;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (gnt) begin
            addr_q    <= addr_q + AddrStep;
            issue_cnt <= issue_cnt_nxt;
          end
          // A raised request is held until granted, without re-checking credit.
          if (req_q && !obi_gnt_i) begin
            req_q <= 1'b1;
          end else begin
            req_q <= (issue_cnt_nxt != '0) && credit_nxt;
          end
          if (gnt && issue_cnt == OneBeat) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && pop_cnt == OneBeat) begin
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          if (done_ready_i) begin
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && obi_rvalid_i && inflight == '0) begin
      assert (stale_ok);
    end
  end

  assign desc_ready_o = ready_q;
  assign obi_req_o    = req_q;
  assign obi_addr_o   = addr_q;
  assign obi_we_o     = 1'b0;
  assign obi_be_o     = '1;
  assign data_valid_o = (fifo_cnt != '0);
  assign data_o       = fifo_mem[rd_ptr][DataWidth-1:0];
  assign data_err_o   = fifo_mem[rd_ptr][DataWidth];
  assign data_last_o  = (pop_cnt == OneBeat);
  assign done_valid_o = done_q;
  assign done_err_o   = err_acc;
  assign busy_o       = (state != IDLE) || (fifo_cnt != '0);
  assign inflight_o   = inflight;

endmodule
`default_nettype wire
